// File: rtl/spi_slave_mem.sv
// spi_slave_mem: SPI mode-0 responder decoding write (0x02) / fast-read (0x0B) into a word memory.
module spi_slave_mem #(
   parameter int DEPTH        = 64,
   parameter int DUMMY_CYCLES = 32
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     spi_sclk,
   input  logic                     spi_sdi,
   input  logic                     spi_cs,
   output logic                     spi_sdo,
   output logic                     wr_valid_o,
   output logic [31:0]              wr_addr_o,
   output logic [31:0]              wr_data_o,
   output logic                     rd_done_o,
   output logic                     err_o,
   input  logic [$clog2(DEPTH)-1:0] dbg_addr_i,
   output logic [31:0]              dbg_data_o
);
   localparam int AW = $clog2(DEPTH);
   typedef enum logic [2:0] {IDLE, CMD, ADDR, WDATA, DUMMY, RDATA, IGNORE} state_t;
   state_t        st, cur;
   logic          sclk_q, rise, fall, is_rd, in_range, mem_we;
   logic [5:0]    cnt;
   logic [31:0]   rx, rx_n, tx, addr;
   logic [31:0]   mem [DEPTH];
   logic [AW-1:0] idx;
   // IDLE with CS low behaves as CMD so a rise in the same cycle is not lost
   assign cur        = (st == IDLE) ? CMD : st;
   assign rise       = ~spi_cs & spi_sclk & ~sclk_q;
   assign fall       = ~spi_cs & ~spi_sclk & sclk_q;
   assign rx_n       = {rx[30:0], spi_sdi};
   assign idx        = addr[AW+1:2];
   assign mem_we     = rise && cur == WDATA && cnt == 6'd31 && in_range;
   assign dbg_data_o = mem[dbg_addr_i];
   always_ff @(posedge clk_i) begin
      if (mem_we) mem[idx] <= rx_n;
   end
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         st         <= IDLE;
         sclk_q     <= 1'b0;
         cnt        <= '0;
         rx         <= '0;
         tx         <= '0;
         addr       <= '0;
         is_rd      <= 1'b0;
         in_range   <= 1'b0;
         spi_sdo    <= 1'b0;
         wr_valid_o <= 1'b0;
         wr_addr_o  <= '0;
         wr_data_o  <= '0;
         rd_done_o  <= 1'b0;
         err_o      <= 1'b0;
      end else begin
         sclk_q     <= spi_sclk;
         wr_valid_o <= 1'b0;
         rd_done_o  <= 1'b0;
         err_o      <= 1'b0;
         if (spi_cs) begin
            st      <= IDLE;
            cnt     <= '0;
            spi_sdo <= 1'b0;
         end else begin
            st <= cur;
            case (cur)
               CMD: if (rise) begin
                  rx  <= rx_n;
                  cnt <= (cnt == 6'd7) ? 6'd0 : cnt + 6'd1;
                  if (cnt == 6'd7) begin
                     is_rd <= rx_n[7:0] == 8'h0B;
                     st    <= (rx_n[7:0] == 8'h02 || rx_n[7:0] == 8'h0B) ? ADDR : IGNORE;
                     err_o <= !(rx_n[7:0] == 8'h02 || rx_n[7:0] == 8'h0B);
                  end
               end
               ADDR: if (rise) begin
                  rx  <= rx_n;
                  cnt <= cnt + 6'd1;
                  if (cnt == 6'd31) begin
                     cnt      <= '0;
                     addr     <= rx_n;
                     in_range <= rx_n[31:AW+2] == '0;
                     err_o    <= rx_n[31:AW+2] != '0;
                     st       <= is_rd ? DUMMY : WDATA;
                  end
               end
               WDATA: if (rise) begin
                  rx  <= rx_n;
                  cnt <= cnt + 6'd1;
                  if (cnt == 6'd31) begin
                     cnt        <= '0;
                     wr_valid_o <= 1'b1;
                     wr_addr_o  <= addr;
                     wr_data_o  <= rx_n;
                     st         <= CMD;
                  end
               end
               DUMMY: if (rise) begin
                  cnt <= cnt + 6'd1;
                  if (cnt == 6'(DUMMY_CYCLES - 1)) begin
                     cnt <= '0;
                     tx  <= in_range ? mem[idx] : '0;
                     st  <= RDATA;
                  end
               end
               RDATA: begin
                  if (fall) begin
                     spi_sdo <= tx[31];
                     tx      <= tx << 1;
                  end
                  if (rise) begin
                     cnt <= cnt + 6'd1;
                     if (cnt == 6'd31) begin
                        cnt       <= '0;
                        rd_done_o <= 1'b1;
                        spi_sdo   <= 1'b0;
                        st        <= CMD;
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_spi_slave_mem.sv
// tb_spi_slave_mem: directed SPI transactions with a queue scoreboard for write/read/error events.
module tb_spi_slave_mem;
   logic        clk_i = 1'b0, rst_ni = 1'b0;
   logic        spi_sclk = 1'b0, spi_sdi = 1'b0, spi_cs = 1'b1;
   logic        spi_sdo, wr_valid_o, rd_done_o, err_o;
   logic [31:0] wr_addr_o, wr_data_o, dbg_data_o;
   logic [5:0]  dbg_addr_i = '0;
   logic [31:0] sh = '0;
   logic [31:0] wq_a[$], wq_d[$], rq[$];
   int          eq[$];
   int          checks = 0, errors = 0;

   spi_slave_mem #(.DEPTH(64), .DUMMY_CYCLES(32)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .spi_sclk(spi_sclk), .spi_sdi(spi_sdi), .spi_cs(spi_cs),
      .spi_sdo(spi_sdo), .wr_valid_o(wr_valid_o), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o),
      .rd_done_o(rd_done_o), .err_o(err_o), .dbg_addr_i(dbg_addr_i), .dbg_data_o(dbg_data_o));

   always #5 clk_i = ~clk_i;

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%h exp=%h", n, act, exp);
      end
   endtask

   // master samples spi_sdo on every sclk rise
   always @(posedge spi_sclk) sh <= {sh[30:0], spi_sdo};

   always @(negedge clk_i) if (rst_ni) begin
      if (wr_valid_o) begin
         if (wq_a.size() == 0) chk("wr_unexpected", 1, 0);
         else begin
            chk("wr_addr", wr_addr_o, wq_a.pop_front());
            chk("wr_data", wr_data_o, wq_d.pop_front());
         end
      end
      if (rd_done_o) begin
         if (rq.size() == 0) chk("rd_unexpected", 1, 0);
         else chk("rd_data", sh, rq.pop_front());
      end
      if (err_o) begin
         if (eq.size() == 0) chk("err_unexpected", 1, 0);
         else void'(eq.pop_front());
      end
   end

   task automatic bit_x(input logic b);
      spi_sdi = b;
      repeat (2) @(negedge clk_i);
      spi_sclk = 1'b1;
      repeat (2) @(negedge clk_i);
      spi_sclk = 1'b0;
   endtask

   task automatic send(input logic [31:0] v, input int n);
      for (int i = n - 1; i >= 0; i--) bit_x(v[i]);
   endtask

   task automatic cs_low();
      spi_cs = 1'b0;
      repeat (2) @(negedge clk_i);
   endtask

   task automatic cs_high();
      spi_cs = 1'b1;
      repeat (3) @(negedge clk_i);
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      wq_a.push_back(a);
      wq_d.push_back(d);
      if (a[31:8] != 0) eq.push_back(1);
      send(32'h02, 8);
      send(a, 32);
      send(d, 32);
   endtask

   task automatic rd(input logic [31:0] a, input logic [31:0] exp);
      rq.push_back(exp);
      if (a[31:8] != 0) eq.push_back(1);
      send(32'h0B, 8);
      send(a, 32);
      send(32'h0, 32);
      send(32'h0, 32);
   endtask

   task automatic peek(input string n, input logic [5:0] i, input logic [31:0] exp);
      dbg_addr_i = i;
      #1 chk(n, dbg_data_o, exp);
   endtask

   initial begin
      repeat (3) @(negedge clk_i);
      chk("rst_sdo", {31'b0, spi_sdo}, 0);
      chk("rst_wr_valid", {31'b0, wr_valid_o}, 0);
      chk("rst_rd_done", {31'b0, rd_done_o}, 0);
      chk("rst_err", {31'b0, err_o}, 0);
      chk("rst_wr_addr", wr_addr_o, 0);
      chk("rst_wr_data", wr_data_o, 0);
      rst_ni = 1'b1;
      repeat (2) @(negedge clk_i);
      cs_low(); wr(32'h64, 32'h64); cs_high();
      peek("dbg_w25", 6'd25, 32'h64);
      cs_low();
      wr(32'h64, 32'h64);
      rd(32'h64, 32'h64);
      wr(32'h8, 32'hDEADBEEF);
      rd(32'h8, 32'hDEADBEEF);
      cs_high();
      peek("dbg_w2", 6'd2, 32'hDEADBEEF);
      cs_low();
      eq.push_back(1);
      send(32'h55, 8);
      send(32'h0200_0064, 32);
      chk("ignore_sdo", {31'b0, spi_sdo}, 0);
      cs_high();
      cs_low(); wr(32'h10, 32'h12345678); cs_high();
      peek("dbg_w4", 6'd4, 32'h12345678);
      cs_low();
      wr(32'h0, 32'hCAFEF00D);
      wr(32'h1000, 32'h11111111);
      rd(32'h1000, 32'h0);
      cs_high();
      peek("dbg_w0_oor", 6'd0, 32'hCAFEF00D);
      cs_low(); wr(32'h20, 32'h0BADCAFE); cs_high();
      cs_low();
      send(32'h02, 8);
      send(32'h20, 32);
      send(32'hFFFFFFFF, 20);
      cs_high();
      peek("dbg_w8_partial", 6'd8, 32'h0BADCAFE);
      cs_low(); wr(32'h20, 32'h600DD00D); cs_high();
      peek("dbg_w8_full", 6'd8, 32'h600DD00D);
      cs_low();
      send(32'h0B, 8);
      send(32'h8, 32);
      send(32'h0, 32);
      send(32'h0, 8);
      @(negedge clk_i);
      chk("mid_read_sdo", {31'b0, spi_sdo}, 1);
      rst_ni = 1'b0;
      #1;
      chk("rst_async_sdo", {31'b0, spi_sdo}, 0);
      chk("rst_async_wr_addr", wr_addr_o, 0);
      spi_cs = 1'b1;
      repeat (2) @(negedge clk_i);
      rst_ni = 1'b1;
      peek("dbg_w2_kept", 6'd2, 32'hDEADBEEF);
      peek("dbg_w25_kept", 6'd25, 32'h64);
      repeat (2) @(negedge clk_i);
      cs_low(); rd(32'h64, 32'h64); cs_high();
      repeat (4) @(negedge clk_i);
      chk("wq_empty", 32'(wq_a.size()), 0);
      chk("rq_empty", 32'(rq.size()), 0);
      chk("eq_empty", 32'(eq.size()), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
